// File: rtl/lif_scheduler.sv
// Shares one external LIF update core across N_NEURONS virtual neurons, sweeping them in index order on each tick.
// Latency is 2 cycles per neuron, plus 1 cycle per spike; a stalled spike (spike_ready low) holds the sweep indefinitely.
module lif_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2,
    parameter int STATE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               cur_wr_en,
    input  logic [IDX_W-1:0]   cur_wr_idx,
    input  logic [STATE_W-1:0] cur_wr_data,
    output logic               core_req,
    output logic [STATE_W-1:0] core_state_o,
    output logic [STATE_W-1:0] core_current_o,
    input  logic [STATE_W-1:0] core_state_i,
    input  logic               core_spike_i,
    output logic               spike_valid,
    output logic [IDX_W-1:0]   spike_id,
    input  logic               spike_ready,
    output logic               busy,
    output logic               tick_overrun,
    input  logic [IDX_W-1:0]   state_rd_idx,
    output logic [STATE_W-1:0] state_rd_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, EMIT} fsm_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    fsm_t               fsm;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic               advance;
    logic               last;
    logic [STATE_W-1:0] state_mem [N_NEURONS];
    logic [STATE_W-1:0] cur_mem   [N_NEURONS];

    assign idx_inc       = idx + IDX_W'(1);
    assign last          = (idx == LAST_IDX);
    assign advance       = ((fsm == CAPTURE) && !core_spike_i) || ((fsm == EMIT) && spike_ready);
    assign state_rd_data = state_mem[state_rd_idx];

    // Operands are latched on entry to ISSUE, so a current write landing in the ISSUE cycle only affects the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm            <= IDLE;
            idx            <= '0;
            core_req       <= 1'b0;
            core_state_o   <= '0;
            core_current_o <= '0;
            spike_valid    <= 1'b0;
            spike_id       <= '0;
            busy           <= 1'b0;
            tick_overrun   <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                state_mem[i] <= '0;
            end
        end else begin
            core_req <= 1'b0;
            if (tick && (fsm != IDLE)) begin
                tick_overrun <= 1'b1;
            end
            case (fsm)
                IDLE: begin
                    if (tick) begin
                        fsm            <= ISSUE;
                        idx            <= '0;
                        busy           <= 1'b1;
                        core_req       <= 1'b1;
                        core_state_o   <= state_mem[0];
                        core_current_o <= cur_mem[0];
                    end
                end
                ISSUE: fsm <= CAPTURE;
                CAPTURE: begin
                    state_mem[idx] <= core_state_i;
                    if (core_spike_i) begin
                        fsm         <= EMIT;
                        spike_valid <= 1'b1;
                        spike_id    <= idx;
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
            if (advance) begin
                if (last) begin
                    fsm  <= IDLE;
                    idx  <= '0;
                    busy <= 1'b0;
                end else begin
                    fsm            <= ISSUE;
                    idx            <= idx_inc;
                    core_req       <= 1'b1;
                    core_state_o   <= state_mem[idx_inc];
                    core_current_o <= cur_mem[idx_inc];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cur_mem[i] <= '0;
            end
        end else if (cur_wr_en) begin
            cur_mem[cur_wr_idx] <= cur_wr_data;
        end
    end

endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler: table of current/tick vectors plus hand sequences for reset, backpressure, overrun and write collision.
// Spike ids are predicted by a reference model when each tick is driven and checked on every handshake.
module tb_lif_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          cur_wr_en = 1'b0;
    logic [IW-1:0] cur_wr_idx = '0;
    logic [SW-1:0] cur_wr_data = '0;
    logic          core_req;
    logic [SW-1:0] core_state_o;
    logic [SW-1:0] core_current_o;
    logic [SW-1:0] core_state_i;
    logic          core_spike_i;
    logic          spike_valid;
    logic [IW-1:0] spike_id;
    logic          spike_ready = 1'b1;
    logic          busy;
    logic          tick_overrun;
    logic [IW-1:0] state_rd_idx = '0;
    logic [SW-1:0] state_rd_data;

    lif_scheduler #(.N_NEURONS(N), .IDX_W(IW), .STATE_W(SW)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cur_wr_en(cur_wr_en), .cur_wr_idx(cur_wr_idx), .cur_wr_data(cur_wr_data),
        .core_req(core_req), .core_state_o(core_state_o), .core_current_o(core_current_o),
        .core_state_i(core_state_i), .core_spike_i(core_spike_i),
        .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
        .busy(busy), .tick_overrun(tick_overrun),
        .state_rd_idx(state_rd_idx), .state_rd_data(state_rd_data)
    );

    always #10 clk = ~clk;

    // External core: next = state + current, spike and reset to 0 at >= 200, one-cycle latency.
    logic [SW:0] core_sum;
    assign core_sum = {1'b0, core_state_o} + {1'b0, core_current_o};
    always @(posedge clk) begin
        if (rst) begin
            core_state_i <= '0;
            core_spike_i <= 1'b0;
        end else if (core_req) begin
            if (core_sum >= 9'd200) begin
                core_state_i <= '0;
                core_spike_i <= 1'b1;
            end else begin
                core_state_i <= core_sum[SW-1:0];
                core_spike_i <= 1'b0;
            end
        end else begin
            core_spike_i <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_req, cnt_busy, cnt_sv;
    int exp_q[$];
    logic [SW-1:0] ref_state [N];
    logic [SW-1:0] ref_cur   [N];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (core_req)    cnt_req++;
            if (busy)        cnt_busy++;
            if (spike_valid) cnt_sv++;
            if (spike_valid && spike_ready) begin
                if (exp_q.size() == 0) check("unexpected_spike", int'(spike_id), -1);
                else check("spike_id", int'(spike_id), exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            ref_state[i] = '0;
            ref_cur[i]   = '0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        cur_wr_en = 1'b0;
        spike_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_cur(input int i, input int v);
        cur_wr_en   = 1'b1;
        cur_wr_idx  = IW'(i);
        cur_wr_data = SW'(v);
        step();
        cur_wr_en   = 1'b0;
        ref_cur[i]  = SW'(v);
    endtask

    task automatic do_tick();
        for (int i = 0; i < N; i++) begin
            int s;
            s = int'(ref_state[i]) + int'(ref_cur[i]);
            if (s >= 200) begin
                exp_q.push_back(i);
                ref_state[i] = '0;
            end else begin
                ref_state[i] = SW'(s);
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("sweep_timeout", int'(busy), 0);
        step();
    endtask

    task automatic check_states(input string tag, input logic [3:0][7:0] exp);
        for (int i = 0; i < N; i++) begin
            state_rd_idx = IW'(i);
            #1;
            check($sformatf("%s_state%0d", tag, i), int'(state_rd_data), int'(exp[i]));
        end
    endtask

    typedef struct {
        logic [3:0][7:0] cur;      // index 0 = neuron 0
        int              nticks;
        logic [3:0][7:0] exp_st;
        int              nspk;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{cur: {8'd40, 8'd30, 8'd20, 8'd10},  nticks: 1, exp_st: {8'd40, 8'd30, 8'd20, 8'd10}, nspk: 0};
        vecs[1] = '{cur: {8'd0, 8'd0, 8'd100, 8'd0},    nticks: 2, exp_st: {8'd0, 8'd0, 8'd0, 8'd0},     nspk: 1};
        vecs[2] = '{cur: {8'd0, 8'd0, 8'd100, 8'd0},    nticks: 3, exp_st: {8'd0, 8'd0, 8'd100, 8'd0},   nspk: 1};
        vecs[3] = '{cur: {8'd60, 8'd150, 8'd1, 8'd199}, nticks: 2, exp_st: {8'd120, 8'd0, 8'd2, 8'd0},   nspk: 2};
        vecs[4] = '{cur: {8'd7, 8'd0, 8'd200, 8'd255},  nticks: 1, exp_st: {8'd7, 8'd0, 8'd0, 8'd0},     nspk: 2};

        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_spike_valid", int'(spike_valid), 0);
        check("rst_core_req", int'(core_req), 0);
        check("rst_overrun", int'(tick_overrun), 0);
        check("rst_core_state_o", int'(core_state_o), 0);
        check("rst_core_current_o", int'(core_current_o), 0);
        check("rst_spike_id", int'(spike_id), 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < N; i++) write_cur(i, int'(vecs[v].cur[i]));
            cnt_req = 0; cnt_busy = 0; cnt_sv = 0;
            for (int t = 0; t < vecs[v].nticks; t++) begin
                do_tick();
                wait_idle(100);
            end
            check_states($sformatf("vec%0d", v), vecs[v].exp_st);
            check($sformatf("vec%0d_busy_cycles", v), cnt_busy, 8 * vecs[v].nticks + vecs[v].nspk);
            check($sformatf("vec%0d_req_count", v), cnt_req, 4 * vecs[v].nticks);
            check($sformatf("vec%0d_spike_cycles", v), cnt_sv, vecs[v].nspk);
            check($sformatf("vec%0d_spikes_left", v), exp_q.size(), 0);
        end

        // Reset while neuron 2 is being issued.
        do_reset();
        write_cur(0, 10); write_cur(1, 20); write_cur(2, 30); write_cur(3, 40);
        do_tick();
        repeat (4) step();
        check("midrst_issue2_current", int'(core_current_o), 30);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_spike_valid", int'(spike_valid), 0);
        check("midrst_core_req", int'(core_req), 0);
        check_states("midrst", {8'd0, 8'd0, 8'd0, 8'd0});
        step();
        rst = 1'b0;
        clear_model();
        write_cur(0, 7);
        do_tick();
        check("midrst_restart_req", int'(core_req), 1);
        check("midrst_restart_current", int'(core_current_o), 7);
        wait_idle(100);
        check_states("midrst_after", {8'd0, 8'd0, 8'd0, 8'd7});

        // Spike on neuron 0 held under backpressure.
        do_reset();
        write_cur(0, 200); write_cur(1, 5);
        spike_ready = 1'b0;
        do_tick();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", k), int'(spike_valid), 1);
            check($sformatf("bp_id_%0d", k), int'(spike_id), 0);
            check($sformatf("bp_req_low_%0d", k), int'(core_req), 0);
            step();
        end
        spike_ready = 1'b1;
        step();
        check("bp_valid_drop", int'(spike_valid), 0);
        check("bp_issue1_req", int'(core_req), 1);
        check("bp_issue1_current", int'(core_current_o), 5);
        wait_idle(100);
        check("bp_spikes_left", exp_q.size(), 0);
        check_states("bp", {8'd0, 8'd0, 8'd5, 8'd0});

        // Second tick arrives mid-sweep.
        do_reset();
        write_cur(0, 1); write_cur(1, 2); write_cur(2, 3); write_cur(3, 4);
        cnt_req = 0; cnt_busy = 0; cnt_sv = 0;
        check("ovr_before", int'(tick_overrun), 0);
        do_tick();
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("ovr_set", int'(tick_overrun), 1);
        wait_idle(100);
        repeat (3) step();
        check("ovr_sticky", int'(tick_overrun), 1);
        check("ovr_idle", int'(busy), 0);
        check("ovr_busy_cycles", cnt_busy, 8);
        check("ovr_req_count", cnt_req, 4);
        check_states("ovr", {8'd4, 8'd3, 8'd2, 8'd1});

        // Current write in neuron 2's ISSUE cycle.
        do_reset();
        write_cur(2, 5);
        do_tick();
        repeat (4) step();
        check("col_issue2_req", int'(core_req), 1);
        check("col_issue2_old", int'(core_current_o), 5);
        cur_wr_en = 1'b1; cur_wr_idx = 2'd2; cur_wr_data = 8'd50;
        step();
        cur_wr_en = 1'b0;
        ref_cur[2] = 8'd50;
        wait_idle(100);
        check_states("col_t1", {8'd0, 8'd5, 8'd0, 8'd0});
        do_tick();
        repeat (4) step();
        check("col_issue2_new", int'(core_current_o), 50);
        wait_idle(100);
        check_states("col_t2", {8'd0, 8'd55, 8'd0, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
